align_shift_register: RTL
=========================

Name: align_shift_register

Overview:
Parametrised, multi-cycle successor to the 24-bit bidirectional mantissa shift register.
- Loads an operand, then shifts it right (exponent alignment) or left by a requested amount, up to MAX_STEP bit positions per clock.
- Maintains IEEE guard/round/sticky bits throughout the shift.
- Uses a start/busy/done handshake.
- Sits between the exponent-difference logic and the mantissa adder; the normalise path is reused after the add.

Parameters:
WIDTH, 24, mantissa width in bits including the hidden bit.
MAX_STEP, 4, maximum bit positions shifted per clock; power of two, 1..WIDTH.
AMT_W, 8, width of the shift-amount input.

Ports:
Clk  input  1  clock, rising edge.
Clear  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
mode  input  2  00 load only, 01 shift right, 10 shift left, 11 normalise (see Optional Feature).
I  input  WIDTH  operand, captured on accepted start.
amt  input  AMT_W  shift amount, captured on accepted start.
busy  output  1  high from the cycle after an accepted start through the DONE cycle.
done  output  1  one-cycle pulse when the result is valid.
A  output  WIDTH  shifted result; holds until the next accepted start.
guard  output  1  first bit shifted out.
round  output  1  second bit shifted out.
sticky  output  1  OR of all bits below round.
norm_cnt  output  AMT_W  left-shift count performed by normalise; 0 otherwise.

Behaviour:
- Reset, and any cycle with Clear=1 including mid-operation:
  - A, guard, round, sticky, norm_cnt = 0; busy = 0; done = 0; state = IDLE.
  - Clear has priority over start.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 accepted:
  - A<=I; guard, round, sticky <= 0; norm_cnt <= 0.
  - rem <= min(amt, WIDTH+2) for right shifts, min(amt, WIDTH) for left shifts.
  - Go to SHIFT, or directly to DONE if rem=0 or mode=00.
- SHIFT: each cycle shifts n = min(rem, MAX_STEP) positions; rem -= n; go to DONE when rem reaches 0.
  - Right shift: the {A,guard,round} vector shifts right by n, zeros enter the MSB, and sticky |= OR of all bits leaving round.
  - Left shift: the {A,guard,round} vector shifts left by n, zeros enter at round, and sticky holds.
- DONE: done=1 for one cycle, then IDLE.
- Latency: start accepted in cycle 0; done in cycle ceil(rem/MAX_STEP)+1; for rem=0 done in cycle 1.
- start while busy is ignored; no queuing. I and amt are don't-care outside the accepted start cycle.
- Back-to-back: start may be accepted in the cycle immediately after DONE.

Optional Feature:
Macro ALIGN_NORMALISE_EN.
- With the macro:
  - mode=11 shifts left one bit per SHIFT cycle, counting into norm_cnt, until A[WIDTH-1]=1.
  - amt is ignored.
  - I=0 terminates with norm_cnt=WIDTH, A=0.
  - guard and round shift in as in a left shift.
- Without the macro: mode=11 behaves as mode=00 and norm_cnt is tied to 0.

Decomposition:
- Package align_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - mode encodings MODE_LOAD, MODE_RIGHT, MODE_LEFT, MODE_NORM.
- One sub-module, grs_step_shifter: combinational shift of {A,guard,round,sticky} by 0..MAX_STEP in either direction, instantiated once in the datapath.

Test Plan:
1. I=0x060002, mode=01, amt=3 -> done in cycle 2; A=0x00C000, guard=0, round=1, sticky=0.
2. I=0x060080, mode=01, amt=9 -> 3 SHIFT cycles, done in cycle 4; A=0x000300, guard=0, round=1, sticky=0.
3. I=0x000001, mode=01, amt=30 (saturates to 26) -> A=0, guard=0, round=0, sticky=1.
4. I=0x060002, mode=10, amt=2 -> A=0x180008, guard=round=sticky=0; a second start pulsed while busy is ignored.
5. Clear asserted in the 2nd SHIFT cycle of scenario 2 -> next cycle all outputs 0, busy=0, no done pulse.
6. With ALIGN_NORMALISE_EN: I=0x000300, mode=11 -> A=0xC00000, norm_cnt=14, done in cycle 15; without the macro -> A=0x000300, norm_cnt=0, done in cycle 1.

Source files
------------

// File: rtl/align_pkg.sv
// -----------------------------------------------------------------------------
// align_pkg
// Shared definitions for the alignment shift register.
//   state_t : controller states (IDLE, SHIFT, DONE)
//   MODE_*  : encodings of the 2-bit mode input
// -----------------------------------------------------------------------------
package align_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_LOAD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_NORM  = 2'b11;

endpackage

// File: rtl/grs_step_shifter.sv
// -----------------------------------------------------------------------------
// grs_step_shifter
// Combinational one-step shifter for the {a, g, r} vector plus sticky.
// Shifts by n = 0..MAX_STEP positions, right or left.
//   a, g, r, s  : current mantissa, guard, round, sticky
//   left        : 1 = shift left (zeros enter at round, sticky held)
//                 0 = shift right (zeros enter at MSB, sticky collects
//                     every bit that falls off below round)
//   n           : shift distance this step
//   a_out..s_out: shifted result
// -----------------------------------------------------------------------------
module grs_step_shifter #(
   parameter int WIDTH    = 24,
   parameter int MAX_STEP = 4,
   parameter int N_W      = $clog2(MAX_STEP + 1)
) (
   input  logic [WIDTH-1:0] a,
   input  logic             g,
   input  logic             r,
   input  logic             s,
   input  logic             left,
   input  logic [N_W-1:0]   n,
   output logic [WIDTH-1:0] a_out,
   output logic             g_out,
   output logic             r_out,
   output logic             s_out
);

   localparam int VW = WIDTH + 2;

   logic [VW-1:0] vec;
   logic [VW-1:0] right_v [0:MAX_STEP];
   logic [VW-1:0] left_v  [0:MAX_STEP];
   logic          right_s [0:MAX_STEP];
   logic [VW-1:0] sel_v;
   logic          sel_s;

   assign vec = {a, g, r};

   // One candidate per legal distance; the mux below picks one.
   generate
      for (genvar gi = 0; gi <= MAX_STEP; gi++) begin : g_dist
         assign right_v[gi] = vec >> gi;
         assign left_v[gi]  = vec << gi;
         if (gi == 0) begin : g_zero
            assign right_s[gi] = s;
         end else begin : g_nz
            assign right_s[gi] = s | (|vec[gi-1:0]);
         end
      end
   endgenerate

   always_comb begin
      sel_v = vec;
      sel_s = s;
      for (int k = 0; k <= MAX_STEP; k++) begin
         if (n == N_W'(k)) begin
            sel_v = left ? left_v[k] : right_v[k];
            sel_s = left ? s : right_s[k];
         end
      end
   end

   assign a_out = sel_v[VW-1:2];
   assign g_out = sel_v[1];
   assign r_out = sel_v[0];
   assign s_out = sel_s;

endmodule

// File: rtl/align_shift_register.sv
// -----------------------------------------------------------------------------
// align_shift_register
// Multi-cycle mantissa alignment / normalise shifter with guard, round and
// sticky tracking, up to MAX_STEP positions per clock.
// Ports:
//   Clk      : clock, rising edge
//   Clear    : synchronous active-high reset (wins over start)
//   start    : request, sampled only in IDLE
//   mode     : 00 load, 01 right, 10 left, 11 normalise
//   I, amt   : operand and shift amount, captured on accepted start
//   busy     : high from the cycle after accept through the DONE cycle
//   done     : one-cycle result-valid pulse
//   A        : result; guard/round/sticky: rounding bits
//   norm_cnt : left shifts performed by normalise, else 0
// Optional feature macro: ALIGN_NORMALISE_EN enables mode 11 normalise;
// without it mode 11 acts as load-only and norm_cnt stays 0.
// -----------------------------------------------------------------------------
module align_shift_register #(
   parameter int WIDTH    = 24,
   parameter int MAX_STEP = 4,
   parameter int AMT_W    = 8
) (
   input  logic             Clk,
   input  logic             Clear,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] I,
   input  logic [AMT_W-1:0] amt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] A,
   output logic             guard,
   output logic             round,
   output logic             sticky,
   output logic [AMT_W-1:0] norm_cnt
);
   import align_pkg::*;

   localparam int REM_W = $clog2(WIDTH + 3);
   localparam int N_W   = $clog2(MAX_STEP + 1);

   state_t           state_reg, state_next;
   logic [1:0]       mode_reg;
   logic [REM_W-1:0] rem_reg, rem_start;
   logic [31:0]      amt_ext, amt_lim;
   logic [N_W-1:0]   step_n;
   logic             shift_left, is_norm;
   logic [WIDTH-1:0] sh_a;
   logic             sh_g, sh_r, sh_s;

   // Right shifts can usefully move everything through guard and round,
   // so they saturate two positions later than left shifts.
   always_comb begin
      amt_ext   = 32'(amt);
      amt_lim   = (mode == MODE_RIGHT) ? 32'(WIDTH + 2) : 32'(WIDTH);
      rem_start = REM_W'((amt_ext > amt_lim) ? amt_lim : amt_ext);
   end

`ifdef ALIGN_NORMALISE_EN
   assign is_norm = (mode_reg == MODE_NORM);
`else
   assign is_norm = 1'b0;
`endif

   assign shift_left = (mode_reg != MODE_RIGHT);
   assign step_n = is_norm ? N_W'(1) :
                   (rem_reg > REM_W'(MAX_STEP)) ? N_W'(MAX_STEP) : rem_reg[N_W-1:0];

   grs_step_shifter #(
      .WIDTH    (WIDTH),
      .MAX_STEP (MAX_STEP),
      .N_W      (N_W)
   ) u_shift (
      .a     (A),
      .g     (guard),
      .r     (round),
      .s     (sticky),
      .left  (shift_left),
      .n     (step_n),
      .a_out (sh_a),
      .g_out (sh_g),
      .r_out (sh_r),
      .s_out (sh_s)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (mode == MODE_LOAD) begin
                  state_next = DONE;
               end else if (mode == MODE_NORM) begin
`ifdef ALIGN_NORMALISE_EN
                  // Already normalised operands need no shift cycle.
                  state_next = I[WIDTH-1] ? DONE : SHIFT;
`else
                  state_next = DONE;
`endif
               end else begin
                  state_next = (rem_start == '0) ? DONE : SHIFT;
               end
            end
         end
         SHIFT: begin
            if (is_norm) begin
               // Stop on a leading one, or after WIDTH shifts for a zero operand.
               if (sh_a[WIDTH-1] || (norm_cnt == AMT_W'(WIDTH - 1)))
                  state_next = DONE;
            end else if (rem_reg == REM_W'(step_n)) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Clear) begin
         state_reg <= IDLE;
         mode_reg  <= MODE_LOAD;
         rem_reg   <= '0;
         A         <= '0;
         guard     <= 1'b0;
         round     <= 1'b0;
         sticky    <= 1'b0;
         norm_cnt  <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  A        <= I;
                  guard    <= 1'b0;
                  round    <= 1'b0;
                  sticky   <= 1'b0;
                  norm_cnt <= '0;
                  rem_reg  <= rem_start;
                  mode_reg <= mode;
               end
            end
            SHIFT: begin
               A       <= sh_a;
               guard   <= sh_g;
               round   <= sh_r;
               sticky  <= sh_s;
               rem_reg <= rem_reg - REM_W'(step_n);
`ifdef ALIGN_NORMALISE_EN
               if (is_norm)
                  norm_cnt <= norm_cnt + AMT_W'(1);
`endif
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_reg != IDLE);
   assign done = (state_reg == DONE);

endmodule
